// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Bridges a CPU load/store request onto a simple word-wide data memory.
//   Handles byte/half/word sizes, sign or zero extension of loads,
//   read-modify-write for sub-word stores, and alignment checking.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - synchronous, active-high reset
//   req        - access request, only looked at while busy=0
//   we         - 1=store, 0=load
//   size       - 00=byte, 01=half, 10=word, 11=reserved (always misaligned)
//   sext       - loads: 1=sign-extend, 0=zero-extend
//   addr       - byte address
//   wdata      - store data, right-aligned
//   busy       - an access is in progress
//   done       - one-cycle completion pulse
//   misalign   - error flag, meaningful only while done=1
//   rdata      - extended load result, held until the next load captures
//   mem_addr   - word address addr[AW+1:2], held for the whole access
//   mem_re     - memory read strobe (data returns the following cycle)
//   mem_we     - memory write strobe
//   mem_wdata  - full word written to memory
//   mem_rdata  - memory read data, valid the cycle after mem_re
//   state_dbg  - current FSM state encoding (IDLE=0 READ=1 CAPT=2 WRITE=3 DONE=4)
//
// Handshake: a request is accepted on a rising edge where the unit is idle
// (busy=0) and req=1; all request fields are latched on that edge. While
// busy=1 req and the request fields are ignored. Completion is signalled by
// a single-cycle done pulse, after which the unit is idle for at least one
// cycle before the next acceptance.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          misalign,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched request fields
  logic        we_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  // Store word: raw wdata at acceptance, replaced by the merged word in CAPT
  logic [31:0] word_q;
  logic        mis_q;

  logic        accept;
  logic        mis_in;

  // Address bits above the memory word address are not used by the memory.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:AW+2];

  assign accept = (state == IDLE) && req;

  // Alignment check on the live request fields, used only at acceptance.
  assign mis_in = (size == 2'b11) ||
                  ((size == 2'b01) && addr[0]) ||
                  ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  a,
                                          input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the read word with the store data.
  function automatic logic [31:0] merge(input logic [31:0] w,
                                        input logic [31:0] wd,
                                        input logic [1:0]  sz,
                                        input logic [1:0]  a);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (a)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else begin
      if (a[1]) r[31:16] = wd[15:0];
      else      r[15:0]  = wd[15:0];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (mis_in)                         state_nxt = DONE;
          else if (we && (size == 2'b10))     state_nxt = WRITE;
          else                                state_nxt = READ;
        end
      end
      READ:    state_nxt = CAPT;
      // Loads finish after capture; sub-word stores go on to write back.
      CAPT:    state_nxt = we_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    misalign  = (state == DONE) && mis_q;
    mem_re    = (state == READ);
    mem_we    = (state == WRITE);
    mem_addr  = addr_q[AW+1:2];
    mem_wdata = word_q;
    state_dbg = state;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      size_q <= 2'b00;
      sext_q <= 1'b0;
      addr_q <= 32'd0;
      word_q <= 32'd0;
      mis_q  <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      if (accept) begin
        we_q   <= we;
        size_q <= size;
        sext_q <= sext;
        addr_q <= addr;
        word_q <= wdata;
        mis_q  <= mis_in;
      end
      // mem_rdata is valid in CAPT (one cycle after READ). Misaligned
      // accesses never reach CAPT, so rdata is untouched by them.
      if (state == CAPT) begin
        if (we_q) word_q <= merge(mem_rdata, word_q, size_q, addr_q[1:0]);
        else      rdata  <= extract(mem_rdata, size_q, addr_q[1:0], sext_q);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. The driver issues accesses and pushes
// the expected completion (absolute done cycle, memory strobe counts,
// misalign, rdata) onto exp_q and expected memory writes onto wr_q. A
// monitor on the falling edge pops and compares whenever done or mem_we is
// seen. A behavioural word memory answers mem_re one cycle later.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int AW = 10;
  localparam int EW = 53;  // {done_cyc[15:0], n_re[1:0], n_we[1:0], mis, rdata[31:0]}
  localparam int WW = 42;  // {word_addr[9:0], data[31:0]}

  // Clock / reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT signals
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sext;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          misalign;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [2:0]    state_dbg;

  mem_access_unit #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sext      (sext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // Behavioural data memory
  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Cycle counter: value seen after edge n is n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] wr_q[$];
  int tests = 0;
  int fails = 0;
  logic [1:0] re_cnt = 2'd0;
  logic [1:0] we_cnt = 2'd0;

  // Monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    logic [WW-1:0] ew;
    if (rst) begin
      re_cnt <= 2'd0;
      we_cnt <= 2'd0;
    end else begin
      if (mem_re && mem_we) begin
        tests++;
        fails++;
        $display("FAIL strobe_excl: mem_re=%0b mem_we=%0b both high at cycle %0d", mem_re, mem_we, cyc);
      end
      if (mem_we) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL mem_write: unexpected write addr=%0d data=%h at cycle %0d", mem_addr, mem_wdata, cyc);
        end else begin
          ew = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== ew) begin
            fails++;
            $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     mem_addr, mem_wdata, ew[41:32], ew[31:0]);
          end
        end
      end
      if (done) begin
        tests++;
        g = {cyc[15:0], re_cnt + {1'b0, mem_re}, we_cnt + {1'b0, mem_we}, misalign, rdata};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL done_check: unexpected done at cycle %0d mis=%0b rdata=%h", cyc, misalign, rdata);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL done_check: got cyc=%0d re=%0d we=%0d mis=%0b rdata=%h, expected cyc=%0d re=%0d we=%0d mis=%0b rdata=%h",
                     g[52:37], g[36:35], g[34:33], g[32], g[31:0],
                     e[52:37], e[36:35], e[34:33], e[32], e[31:0]);
          end
        end
        re_cnt <= 2'd0;
        we_cnt <= 2'd0;
      end else begin
        if (mem_re) re_cnt <= re_cnt + 2'd1;
        if (mem_we) we_cnt <= we_cnt + 2'd1;
      end
    end
  end

  // Direct check helper
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Wait for the unit to return idle, bounded.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0b after 20 cycles, expected 0", busy);
    end
  endtask

  // Issue one access. lat = cycles from the acceptance cycle to done.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input logic mis,
                        input logic [1:0] n_re, input logic [1:0] n_we,
                        input logic [31:0] exp_rd,
                        input bit has_wr, input logic [31:0] wr_data);
    int acc;
    logic [15:0] dc;
    if (has_wr) wr_q.push_back({a[AW+1:2], wr_data});
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    // Acceptance cycle is the one that ended at this edge.
    acc = cyc - 1;
    req = 1'b0;
    dc = 16'(acc + lat);
    exp_q.push_back({dc, n_re, n_we, mis, exp_rd});
    wait_idle();
  endtask

  // Stimulus
  initial begin
    int acc1;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
    mem[0] = 32'h8877_66F5;
    mem[1] = 32'h1234_ABCD;
    mem[2] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_mem_re",   {31'd0, mem_re},   32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_rdata",    rdata,             32'd0);
    chk("rst_state",    {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    // Loads: w sz sx addr wdata lat mis re we exp_rdata has_wr wr_data
    access(0, 2'b00, 1, 32'h0, 32'h0, 3, 0, 1, 0, 32'hFFFF_FFF5, 0, 32'h0);
    access(0, 2'b00, 0, 32'h0, 32'h0, 3, 0, 1, 0, 32'h0000_00F5, 0, 32'h0);
    access(0, 2'b01, 1, 32'h6, 32'h0, 3, 0, 1, 0, 32'h0000_1234, 0, 32'h0);
    access(0, 2'b01, 1, 32'h4, 32'h0, 3, 0, 1, 0, 32'hFFFF_ABCD, 0, 32'h0);
    access(0, 2'b00, 0, 32'h5, 32'h0, 3, 0, 1, 0, 32'h0000_00AB, 0, 32'h0);
    access(0, 2'b00, 1, 32'h7, 32'h0, 3, 0, 1, 0, 32'h0000_0012, 0, 32'h0);
    access(0, 2'b10, 1, 32'h4, 32'h0, 3, 0, 1, 0, 32'h1234_ABCD, 0, 32'h0);

    // Stores: rdata must stay 0x1234ABCD
    mem[0] = 32'h1122_3344;
    access(1, 2'b00, 0, 32'h2, 32'h0000_00AB, 4, 0, 1, 1, 32'h1234_ABCD, 1, 32'h11AB_3344);
    access(1, 2'b01, 0, 32'hA, 32'hFFFF_5555, 4, 0, 1, 1, 32'h1234_ABCD, 1, 32'h5555_BEEF);
    access(1, 2'b10, 0, 32'hC, 32'hCAFE_F00D, 2, 0, 0, 1, 32'h1234_ABCD, 1, 32'hCAFE_F00D);
    access(1, 2'b00, 0, 32'hD, 32'h0000_775A, 4, 0, 1, 1, 32'h1234_ABCD, 1, 32'hCAFE_5A0D);

    // Misaligned: done one cycle after acceptance, no strobes, rdata held
    access(0, 2'b10, 0, 32'h2, 32'h0, 1, 1, 0, 0, 32'h1234_ABCD, 0, 32'h0);
    access(0, 2'b01, 1, 32'h1, 32'h0, 1, 1, 0, 0, 32'h1234_ABCD, 0, 32'h0);
    access(0, 2'b11, 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h1234_ABCD, 0, 32'h0);
    access(1, 2'b10, 0, 32'h5, 32'h0BAD_0BAD, 1, 1, 0, 0, 32'h1234_ABCD, 0, 32'h0);

    // Read back merged words
    access(0, 2'b10, 0, 32'h0, 32'h0, 3, 0, 1, 0, 32'h11AB_3344, 0, 32'h0);
    access(0, 2'b10, 0, 32'h8, 32'h0, 3, 0, 1, 0, 32'h5555_BEEF, 0, 32'h0);
    access(0, 2'b10, 0, 32'hC, 32'h0, 3, 0, 1, 0, 32'hCAFE_5A0D, 0, 32'h0);

    // Busy: req held high for two word stores; second accepted 3 cycles
    // after the first, changes while busy are ignored.
    wr_q.push_back({10'd4, 32'h0102_0304});
    wr_q.push_back({10'd5, 32'h0506_0708});
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0;
    addr = 32'h10; wdata = 32'h0102_0304;
    @(posedge clk);
    #1;
    acc1 = cyc - 1;
    exp_q.push_back({16'(acc1 + 2), 2'd0, 2'd1, 1'b0, 32'hCAFE_5A0D});
    exp_q.push_back({16'(acc1 + 5), 2'd0, 2'd1, 1'b0, 32'hCAFE_5A0D});
    addr = 32'h14; wdata = 32'h0506_0708;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    // Load request pulse while the second store is in flight
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h0;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("busy_mem4", mem[4], 32'h0102_0304);
    chk("busy_mem5", mem[5], 32'h0506_0708);

    // Mid-access reset in CAPT of a half store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; addr = 32'h4; wdata = 32'h0000_7777;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_capt_state", {29'd0, state_dbg}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_done",  {31'd0, done},      32'd0);
    chk("abort_state", {29'd0, state_dbg}, 32'd0);
    chk("abort_rdata", rdata,              32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_mem1", mem[1], 32'h1234_ABCD);

    // Unit is usable after the abort
    access(0, 2'b01, 0, 32'h4, 32'h0, 3, 0, 1, 0, 32'h0000_ABCD, 0, 32'h0);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("wr_q_empty",  wr_q.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
